// File: rtl/sdpram_pipe_pkg.sv
// sdpram_pkg: shared collision-mode type and byte-merge helpers for sdpram_pipe
package sdpram_pkg;
  typedef enum logic {READ_FIRST, WRITE_FIRST} collision_mode_e;
  localparam int MAX_DW = 1024;
  localparam int MAX_NB = MAX_DW / 8;
  function automatic int strb_width(input int data_width, input int byte_write);
    return byte_write != 0 ? data_width / 8 : 1;
  endfunction
  function automatic logic [MAX_DW-1:0] byte_merge(
    input logic [MAX_DW-1:0] old_d,
    input logic [MAX_DW-1:0] new_d,
    input logic [MAX_NB-1:0] strb
  );
    logic [MAX_DW-1:0] r;
    r = old_d;
    for (int i = 0; i < MAX_NB; i++) r[i*8 +: 8] = strb[i] ? new_d[i*8 +: 8] : old_d[i*8 +: 8];
    return r;
  endfunction
endpackage

// File: rtl/sdpram_pipe_if.sv
// sdpram_pipe_if: write port A and read port B of the simple dual-port RAM
interface sdpram_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int STRB_WIDTH = 1
);
  logic [ADDR_WIDTH-1:0] addra;
  logic [STRB_WIDTH-1:0] wena;
  logic [DATA_WIDTH-1:0] dina;
  logic [ADDR_WIDTH-1:0] addrb;
  logic                  renb;
  logic [DATA_WIDTH-1:0] doutb;
  logic                  dvalb;
  modport master (output addra, wena, dina, addrb, renb, input doutb, dvalb);
  modport slave (input addra, wena, dina, addrb, renb, output doutb, dvalb);
endinterface

// File: rtl/sdpram_pipe_rd_pipe.sv
// sdpram_rd_pipe: data+valid delay line; data stages only advance with a valid beat
module sdpram_rd_pipe #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             vin,
  output logic [WIDTH-1:0] dout,
  output logic             vout
);
  logic [LATENCY-1:0][WIDTH-1:0] d;
  logic [LATENCY-1:0]            v;
  // valid shifts every cycle; data is captured only alongside its valid so the output holds between beats
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      d <= '0;
      v <= '0;
    end else begin
      v[0] <= vin;
      d[0] <= vin ? din : d[0];
      for (int i = 1; i < LATENCY; i++) begin
        v[i] <= v[i-1];
        d[i] <= v[i-1] ? d[i-1] : d[i];
      end
    end
  assign dout = d[LATENCY-1];
  assign vout = v[LATENCY-1];
endmodule

// File: rtl/sdpram_pipe.sv
// sdpram_pipe: simple dual-port RAM with byte strobes, range check, collision bypass and pipelined read
module sdpram_pipe
  import sdpram_pkg::*;
#(
  parameter int              DATA_WIDTH     = 32,
  parameter int              MEM_DEPTH      = 1024,
  parameter int              BYTE_WRITE     = 0,
  parameter int              RD_LATENCY     = 1,
  parameter collision_mode_e COLLISION_MODE = READ_FIRST,
  localparam int             ADDR_WIDTH     = $clog2(MEM_DEPTH),
  localparam int             STRB_WIDTH     = strb_width(DATA_WIDTH, BYTE_WRITE)
) (
  input logic          clk,
  input logic          rst_n,
  sdpram_pipe_if.slave bus
);
  localparam int NB = (DATA_WIDTH + 7) / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_lat
    $error("sdpram_pipe: RD_LATENCY must be 1..3");
  end
  if (BYTE_WRITE != 0 && DATA_WIDTH % 8 != 0) begin : g_bad_dw
    $error("sdpram_pipe: DATA_WIDTH must be a multiple of 8 with BYTE_WRITE");
  end
  if (DATA_WIDTH > MAX_DW) begin : g_too_wide
    $error("sdpram_pipe: DATA_WIDTH exceeds byte_merge capacity");
  end
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [NB-1:0]         strb;
  logic                  wa_ok, wr_ok, rd_ok, hit;
  logic [DATA_WIDTH-1:0] wr_old, wr_new, rd_data;
  if (BYTE_WRITE != 0) begin : g_bw
    assign strb = bus.wena;
  end else begin : g_ww
    assign strb = {NB{bus.wena[0]}};
  end
  assign wa_ok   = {1'b0, bus.addra} < DEPTH;
  assign rd_ok   = {1'b0, bus.addrb} < DEPTH;
  assign wr_ok   = wa_ok && (|strb);
  assign wr_old  = wa_ok ? mem[bus.addra] : '0;
  assign wr_new  = DATA_WIDTH'(byte_merge(MAX_DW'(wr_old), MAX_DW'(bus.dina), MAX_NB'(strb)));
  assign hit     = wr_ok && (bus.addra == bus.addrb);
  assign rd_data = !rd_ok ? '0 : (COLLISION_MODE == WRITE_FIRST && hit) ? wr_new : mem[bus.addrb];
  // array update with the merged word so unstrobed bytes keep their old contents; never reset
  always_ff @(posedge clk)
    if (wr_ok) mem[bus.addra] <= wr_new;
  sdpram_rd_pipe #(
    .WIDTH  (DATA_WIDTH),
    .LATENCY(RD_LATENCY)
  ) u_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (rd_data),
    .vin  (bus.renb),
    .dout (bus.doutb),
    .vout (bus.dvalb)
  );
endmodule
